// File: rtl/ntt_stage_ctrl.sv
// ----------------------------------------------------------------------------
// ntt_stage_ctrl
//
// Sequencer for an in-place N-point decimation-in-frequency (Gentleman-Sande)
// NTT. The transform runs on a radix-2 butterfly pipeline. For each of the
// LOGN stages this block does three things:
//   - it issues N/2 butterflies, one per cycle. Each issue drives a read
//     address pair into the coefficient RAM and an address into the twiddle
//     ROM.
//   - it carries each issue through a delay line of depth 1+BFLY_LAT, so the
//     matching write strobe and write address pair leave the line at the same
//     time as the butterfly result.
//   - it drains the pipeline before the next stage starts, so no stage reads
//     a coefficient that is still in flight.
//
// Parameters
//   LOGN      log2 of the transform size N (2..12)
//   BFLY_LAT  cycles from bf_en to bf_valid (>= 1)
//
// Ports
//   clk        clock, all logic on the rising edge
//   reset      asynchronous, active-high; clears every register
//   start      one-cycle request to begin a transform (ignored unless idle)
//   busy       high from the cycle after start through the last write
//   done       one-cycle pulse after the last write of the last stage
//   stage      current stage index 0..LOGN-1
//   rd_en      coefficient RAM read strobe (RAM read latency 1)
//   rd_addr_a  read address of butterfly operand x
//   rd_addr_b  read address of butterfly operand y
//   tw_addr    twiddle ROM address, aligned with rd_en
//   bf_en      butterfly input enable (rd_en delayed one cycle)
//   bf_valid   butterfly output valid, returned by the butterfly
//   wr_en      coefficient RAM write strobe for xout/yout
//   wr_addr_a  write address of xout
//   wr_addr_b  write address of yout
//   err        sticky: bf_valid disagreed with the expected write slot
// ----------------------------------------------------------------------------
module ntt_stage_ctrl #(
    parameter int LOGN     = 8,
    parameter int BFLY_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [$clog2(LOGN):0] stage,
    output logic                  rd_en,
    output logic [LOGN-1:0]       rd_addr_a,
    output logic [LOGN-1:0]       rd_addr_b,
    output logic [LOGN-2:0]       tw_addr,
    output logic                  bf_en,
    input  logic                  bf_valid,
    output logic                  wr_en,
    output logic [LOGN-1:0]       wr_addr_a,
    output logic [LOGN-1:0]       wr_addr_b,
    output logic                  err
);

    localparam int SW  = $clog2(LOGN) + 1;  // stage counter width
    localparam int AW  = LOGN;              // coefficient address width
    localparam int JW  = LOGN - 1;          // butterfly index / twiddle width
    localparam int DLY = 1 + BFLY_LAT;      // issue-to-write delay line depth

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);
    localparam logic [JW-1:0] LAST_J     = {JW{1'b1}};   // N/2 - 1

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [JW-1:0]   j;
    logic            drain_empty;

    // Next issue selected from the current state (consumed by the address regs)
    logic            iss_go;
    logic [SW-1:0]   iss_stage;
    logic [JW-1:0]   iss_j;

    // Delay line: entry 0 lines up with bf_en, entry DLY-1 with the write slot
    logic            vld_p    [DLY];
    logic [AW-1:0]   addr_a_p [DLY];
    logic [AW-1:0]   addr_b_p [DLY];

    // ------------------------------------------------------------------------
    // Address arithmetic for stage s, butterfly j.
    //   m  = 2^(LOGN-1-s), k = j mod m, g = j / m
    //   a  = g*2m + k   -> j with a zero inserted at bit position LOGN-1-s
    //   b  = a + m      -> the same position set to one
    //   tw = k << s
    // ------------------------------------------------------------------------
    function automatic logic [JW-1:0] low_mask(input logic [SW-1:0] s);
        logic [SW-1:0] sh;
        sh = LAST_STAGE - s;
        return ~({JW{1'b1}} << sh);
    endfunction

    function automatic logic [AW-1:0] span(input logic [SW-1:0] s);
        logic [SW-1:0] sh;
        sh = LAST_STAGE - s;
        return AW'(1) << sh;
    endfunction

    function automatic logic [AW-1:0] addr_x(input logic [SW-1:0] s,
                                             input logic [JW-1:0] jj);
        logic [JW-1:0] msk;
        msk = low_mask(s);
        return {jj & ~msk, 1'b0} | {1'b0, jj & msk};
    endfunction

    function automatic logic [JW-1:0] addr_tw(input logic [SW-1:0] s,
                                              input logic [JW-1:0] jj);
        logic [JW-1:0] msk;
        msk = low_mask(s);
        return (jj & msk) << s;
    endfunction

    // The pipeline is drained when nothing is still ahead of the write slot.
    // The entry sitting in the write slot retires on this edge, so the next
    // stage can issue in the cycle right after the final write.
    always_comb begin
        drain_empty = ~rd_en;
        for (int i = 0; i < DLY - 1; i++) begin
            if (vld_p[i]) begin
                drain_empty = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (j == LAST_J) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    state_nxt = (stage == LAST_STAGE) ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == S_RUN) || (state == S_DRAIN);
        done = (state == S_DONE);
    end

    // Issue selection. j only advances while it is below N/2-1, and the stage
    // only advances while it is below LOGN-1, so neither counter can wrap.
    always_comb begin
        iss_go    = 1'b0;
        iss_stage = stage;
        iss_j     = j;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    iss_go    = 1'b1;
                    iss_stage = '0;
                    iss_j     = '0;
                end
            end
            S_RUN: begin
                if (j != LAST_J) begin
                    iss_go = 1'b1;
                    iss_j  = j + JW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_empty && (stage != LAST_STAGE)) begin
                    iss_go    = 1'b1;
                    iss_stage = stage + SW'(1);
                    iss_j     = '0;
                end
            end
            default: begin
                iss_go = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Issue stage: registered read/twiddle addresses. These hold their value
    // whenever no butterfly is issued.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage     <= '0;
            j         <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            rd_en <= iss_go;
            if (iss_go) begin
                stage     <= iss_stage;
                j         <= iss_j;
                rd_addr_a <= addr_x(iss_stage, iss_j);
                rd_addr_b <= addr_x(iss_stage, iss_j) | span(iss_stage);
                tw_addr   <= addr_tw(iss_stage, iss_j);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Delay line stages 0..DLY-1: the RAM read cycle, then BFLY_LAT butterfly
    // cycles
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DLY; i++) begin
                vld_p[i]    <= 1'b0;
                addr_a_p[i] <= '0;
                addr_b_p[i] <= '0;
            end
        end else begin
            vld_p[0]    <= rd_en;
            addr_a_p[0] <= rd_addr_a;
            addr_b_p[0] <= rd_addr_b;
            for (int i = 1; i < DLY; i++) begin
                vld_p[i]    <= vld_p[i-1];
                addr_a_p[i] <= addr_a_p[i-1];
                addr_b_p[i] <= addr_b_p[i-1];
            end
        end
    end

    assign bf_en     = vld_p[0];
    assign wr_en     = vld_p[DLY-1];
    assign wr_addr_a = addr_a_p[DLY-1];
    assign wr_addr_b = addr_b_p[DLY-1];

    // ------------------------------------------------------------------------
    // Write-slot check: the butterfly must return a result exactly when the
    // delay line expects one
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bf_valid != vld_p[DLY-1]) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ntt_stage_ctrl
//
// Directed bench. It runs two instances of ntt_stage_ctrl:
//   - a small one (LOGN=3, BFLY_LAT=4). Its outputs are compared cycle by
//     cycle with hand-written trace tables.
//   - a large one (LOGN=8, BFLY_LAT=1). Its checks cover issue timing, the
//     address pairing and address coverage, and the cycle on which done fires.
// Each butterfly is modelled as bf_en delayed by BFLY_LAT cycles.
// ----------------------------------------------------------------------------
module tb_ntt_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic start8;
    logic drop;

    // Small instance: LOGN=3, BFLY_LAT=4
    logic       busy, done, rd_en, bf_en, bf_valid, wr_en, err;
    logic [2:0] stage;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;
    logic [3:0] bfq;

    // Large instance: LOGN=8, BFLY_LAT=1
    logic       busy8, done8, rd_en8, bf_en8, bf_valid8, wr_en8, err8;
    logic [3:0] stage8;
    logic [7:0] rd_addr_a8, rd_addr_b8, wr_addr_a8, wr_addr_b8;
    logic [6:0] tw_addr8;

    int n_vec = 0;
    int n_bad = 0;

    // Hand-computed trace tables of the small configuration, indexed [stage][issue]
    int exp_a  [0:2][0:3] = '{'{0, 1, 2, 3}, '{0, 1, 4, 5}, '{0, 2, 4, 6}};
    int exp_b  [0:2][0:3] = '{'{4, 5, 6, 7}, '{2, 3, 6, 7}, '{1, 3, 5, 7}};
    int exp_tw [0:2][0:3] = '{'{0, 1, 2, 3}, '{0, 2, 0, 2}, '{0, 0, 0, 0}};

    ntt_stage_ctrl #(.LOGN(3), .BFLY_LAT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_en     (bf_en),
        .bf_valid  (bf_valid),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .err       (err)
    );

    ntt_stage_ctrl #(.LOGN(8), .BFLY_LAT(1)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .busy      (busy8),
        .done      (done8),
        .stage     (stage8),
        .rd_en     (rd_en8),
        .rd_addr_a (rd_addr_a8),
        .rd_addr_b (rd_addr_b8),
        .tw_addr   (tw_addr8),
        .bf_en     (bf_en8),
        .bf_valid  (bf_valid8),
        .wr_en     (wr_en8),
        .wr_addr_a (wr_addr_a8),
        .wr_addr_b (wr_addr_b8),
        .err       (err8)
    );

    // Butterfly models: results appear BFLY_LAT cycles after bf_en, and are
    // flushed by reset. drop suppresses one result of the small instance.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bfq <= '0;
        end else begin
            bfq <= {bfq[2:0], bf_en};
        end
    end
    assign bf_valid = bfq[3] & ~drop;

    logic bf8q;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bf8q <= 1'b0;
        end else begin
            bf8q <= bf_en8;
        end
    end
    assign bf_valid8 = bf8q;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Small-config schedule, counted in cycles after the start edge
    function automatic bit rd_on(input int c);
        if (c < 1) return 1'b0;
        return ((c - 1) / 9 < 3) && ((c - 1) % 9 < 4);
    endfunction

    function automatic bit wr_on(input int c);
        if (c < 6) return 1'b0;
        return ((c - 6) / 9 < 3) && ((c - 6) % 9 < 4);
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, " busy"},      int'(busy),      0);
        chk({tag, " done"},      int'(done),      0);
        chk({tag, " stage"},     int'(stage),     0);
        chk({tag, " rd_en"},     int'(rd_en),     0);
        chk({tag, " rd_addr_a"}, int'(rd_addr_a), 0);
        chk({tag, " rd_addr_b"}, int'(rd_addr_b), 0);
        chk({tag, " tw_addr"},   int'(tw_addr),   0);
        chk({tag, " bf_en"},     int'(bf_en),     0);
        chk({tag, " wr_en"},     int'(wr_en),     0);
        chk({tag, " wr_addr_a"}, int'(wr_addr_a), 0);
        chk({tag, " wr_addr_b"}, int'(wr_addr_b), 0);
        chk({tag, " err"},       int'(err),       0);
    endtask

    // Called at cycle 1, one step after the start edge. Extra start pulses
    // go on cycles sa/sb/sc. drop_c drops one butterfly result. A reset
    // asserted at rst_c aborts the run.
    task automatic run_small(input int drop_c, input int sa, input int sb,
                             input int sc, input int rst_c);
        int s;
        int i;
        string t;
        for (int c = 1; c <= 28; c++) begin
            start = (c == sa) || (c == sb) || (c == sc);
            drop  = (c == drop_c);
            t = $sformatf("c%0d", c);
            chk({t, " busy"},  int'(busy),  int'(c <= 27));
            chk({t, " done"},  int'(done),  int'(c == 28));
            chk({t, " stage"}, int'(stage), (c - 1) / 9 > 2 ? 2 : (c - 1) / 9);
            chk({t, " rd_en"}, int'(rd_en), int'(rd_on(c)));
            chk({t, " bf_en"}, int'(bf_en), int'(rd_on(c - 1)));
            chk({t, " wr_en"}, int'(wr_en), int'(wr_on(c)));
            chk({t, " err"},   int'(err),   int'(drop_c > 0 && c > drop_c));
            if (rd_on(c)) begin
                s = (c - 1) / 9;
                i = (c - 1) % 9;
                chk({t, " rd_addr_a"}, int'(rd_addr_a), exp_a[s][i]);
                chk({t, " rd_addr_b"}, int'(rd_addr_b), exp_b[s][i]);
                chk({t, " tw_addr"},   int'(tw_addr),   exp_tw[s][i]);
            end
            if (wr_on(c)) begin
                s = (c - 6) / 9;
                i = (c - 6) % 9;
                chk({t, " wr_addr_a"}, int'(wr_addr_a), exp_a[s][i]);
                chk({t, " wr_addr_b"}, int'(wr_addr_b), exp_b[s][i]);
            end
            if (c == rst_c) begin
                start = 1'b0;
                drop  = 1'b0;
                reset = 1'b1;
                #1;
                check_zero("abort");
                @(posedge clk); #1;
                check_zero("abort+1");
                reset = 1'b0;
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk); #1;
                    chk("post-abort done",  int'(done),  0);
                    chk("post-abort busy",  int'(busy),  0);
                    chk("post-abort rd_en", int'(rd_en), 0);
                    chk("post-abort wr_en", int'(wr_en), 0);
                end
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        drop  = 1'b0;
        // Cycle 29: back in IDLE
        chk("c29 busy",  int'(busy),  0);
        chk("c29 done",  int'(done),  0);
        chk("c29 rd_en", int'(rd_en), 0);
        chk("c29 wr_en", int'(wr_en), 0);
        chk("c29 err",   int'(err),   int'(drop_c > 0));
    endtask

    task automatic kick_small();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_big();
        int s;
        int i;
        int done_c;
        int incr;
        int prev_s;
        int dups;
        bit on;
        logic [255:0] seen;
        done_c = -1;
        incr   = 0;
        prev_s = 0;
        dups   = 0;
        seen   = '0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int c = 1; c <= 1100 && done_c < 0; c++) begin
            s  = (c - 1) / 130;
            i  = (c - 1) % 130;
            on = (c <= 1040) && (i < 128);
            chk($sformatf("L8 c%0d rd_en", c), int'(rd_en8), int'(on));
            if (int'(stage8) != prev_s) begin
                incr++;
                prev_s = int'(stage8);
            end
            if (on) begin
                chk($sformatf("L8 c%0d stage", c), int'(stage8), s);
                chk($sformatf("L8 c%0d b-a", c),
                    int'(rd_addr_b8) - int'(rd_addr_a8), 1 << (7 - s));
                if (seen[rd_addr_a8] || seen[rd_addr_b8]) dups++;
                seen[rd_addr_a8] = 1'b1;
                seen[rd_addr_b8] = 1'b1;
                if (i == 127) begin
                    chk($sformatf("L8 s%0d coverage", s), $countones(seen), 256);
                    chk($sformatf("L8 s%0d repeats", s), dups, 0);
                    seen = '0;
                    dups = 0;
                end
            end
            if (done8) begin
                done_c = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("L8 done cycle", done_c, 1041);
        chk("L8 stage increments", incr, 7);
        chk("L8 busy at done", int'(busy8), 0);
        chk("L8 err", int'(err8), 0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        start8 = 1'b0;
        drop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset L8 busy",  int'(busy8),  0);
        chk("reset L8 rd_en", int'(rd_en8), 0);
        chk("reset L8 wr_en", int'(wr_en8), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle rd_en", int'(rd_en), 0);

        // Start pulses while busy and in the done cycle are ignored, then
        // the next transform is started straight away on cycle 29
        kick_small();
        run_small(0, 5, 20, 28, 0);
        kick_small();
        run_small(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;

        // One dropped butterfly result
        kick_small();
        run_small(7, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("sticky err", int'(err), 1);
        reset = 1'b1;
        #1;
        chk("err cleared", int'(err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Abort mid-transform, then a complete clean run
        kick_small();
        run_small(0, 0, 0, 0, 12);
        kick_small();
        run_small(0, 0, 0, 0, 0);

        run_big();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
